// File: rtl/masked_and_scheduler.sv
// Round-robin front end that shares one 2-share masked AND gadget between two requesters.
// Gadget operands are precharged to zero outside issue cycles and the mask comes from a free-running LFSR.
module masked_and_scheduler #(
    parameter int          WIDTH     = 4,
    parameter int          ISSUE_GAP = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [4*WIDTH-1:0]   req_x,
    input  logic [4*WIDTH-1:0]   req_y,
    output logic [1:0]           rsp_valid,
    output logic [2*WIDTH-1:0]   rsp_z,
    output logic [WIDTH-1:0]     g_x0,
    output logic [WIDTH-1:0]     g_x1,
    output logic [WIDTH-1:0]     g_y0,
    output logic [WIDTH-1:0]     g_y1,
    output logic [WIDTH-1:0]     g_random,
    input  logic [WIDTH-1:0]     g_z0,
    input  logic [WIDTH-1:0]     g_z1,
    output logic                 busy,
    output logic [15:0]          issue_count
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [7:0]  GAP  = 8'(ISSUE_GAP);

    // x^16+x^14+x^13+x^11+1, shifted left with the feedback entering bit 0
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    logic                ptr;
    logic [7:0]          gap_cnt;
    logic                vld_s1;
    logic                vld_s2;
    logic                tag_s1;
    logic                tag_s2;
    logic [15:0]         lfsr;
    logic                can_issue;
    logic [1:0]          grant;
    logic                issue;
    logic [2*WIDTH-1:0]  drv_x;
    logic [2*WIDTH-1:0]  drv_y;

    // Round-robin grant from registered state; reset blocks any grant
    always_comb begin
        can_issue = (gap_cnt == 8'd0) && !rst;
        grant     = 2'b00;
        if (!can_issue) begin
            grant = 2'b00;
        end else if (req_valid == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end else begin
            grant = req_valid;
        end
        issue = |grant;
    end

    // Each requester's shares are gated by its own grant bit, so ungranted data never reaches the gadget
    always_comb begin
        drv_x = (req_x[0 +: 2*WIDTH]       & {(2*WIDTH){grant[0]}})
              | (req_x[2*WIDTH +: 2*WIDTH] & {(2*WIDTH){grant[1]}});
        drv_y = (req_y[0 +: 2*WIDTH]       & {(2*WIDTH){grant[0]}})
              | (req_y[2*WIDTH +: 2*WIDTH] & {(2*WIDTH){grant[1]}});
        g_x0  = drv_x[WIDTH-1:0];
        g_x1  = drv_x[2*WIDTH-1:WIDTH];
        g_y0  = drv_y[WIDTH-1:0];
        g_y1  = drv_y[2*WIDTH-1:WIDTH];
    end

    // Arbitration pointer, issue gap, in-flight tags, issue counter and mask LFSR
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= 1'b0;
            gap_cnt     <= 8'd0;
            vld_s1      <= 1'b0;
            vld_s2      <= 1'b0;
            tag_s1      <= 1'b0;
            tag_s2      <= 1'b0;
            issue_count <= 16'd0;
            lfsr        <= SEED;
        end else begin
            lfsr   <= lfsr_step(lfsr);
            vld_s1 <= issue;
            vld_s2 <= vld_s1;
            tag_s2 <= tag_s1;
            if (issue) begin
                ptr         <= ~grant[1];
                gap_cnt     <= GAP;
                issue_count <= issue_count + 16'd1;
                tag_s1      <= grant[1];
            end else if (gap_cnt != 8'd0) begin
                gap_cnt <= gap_cnt - 8'd1;
            end else begin
                gap_cnt <= 8'd0;
            end
        end
    end

    assign req_ready = grant;
    assign rsp_valid = {vld_s2 & tag_s2, vld_s2 & ~tag_s2};
    assign rsp_z     = {g_z1, g_z0};
    assign g_random  = lfsr[WIDTH-1:0];
    assign busy      = vld_s1 | vld_s2 | (gap_cnt != 8'd0);

endmodule

// File: doc/masked_and_scheduler.md
Name: masked_and_scheduler

Overview:
- Front-end controller that shares one 2-share masked AND gadget (2-cycle latency, WIDTH-bit, one fresh random mask) between two requesters.
- Arbitrates round-robin and drives operand shares into the gadget.
- Zeroes (precharges) gadget inputs in idle cycles, supplies fresh randomness every cycle from an internal LFSR, and enforces a programmable minimum issue gap.
- Tracks in-flight operations and routes each result back to the requester that issued it.

Parameters:
- WIDTH, 4, share width in bits (1..16).
- ISSUE_GAP, 0, minimum idle cycles between two issues (0 = back-to-back, max 255).
- LFSR_SEED, 16'hACE1, reset value of the mask LFSR; a value of 0 is replaced by 16'hACE1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  2  bit i: requester i presents an operand.
- req_ready  out  2  bit i: requester i is granted this cycle.
- req_x  in  4*WIDTH  per requester i, slice [2iW+:2W] = {x_share1, x_share0}.
- req_y  in  4*WIDTH  same packing for the y shares.
- rsp_valid  out  2  bit i: result for requester i is on rsp_z this cycle.
- rsp_z  out  2*WIDTH  {z_share1, z_share0}, shared by both requesters.
- g_x0, g_x1, g_y0, g_y1  out  WIDTH each  gadget operand shares.
- g_random  out  WIDTH  gadget fresh mask.
- g_z0, g_z1  in  WIDTH each  gadget output shares.
- busy  out  1  operation in flight or issue gap running.
- issue_count  out  16  number of issues, wraps.

Behaviour:
- Reset (async, immediate):
  - ptr=0, gap_cnt=0, vld_s1=vld_s2=0, tags=0, issue_count=0, lfsr=seed.
  - Outputs settle to req_ready=0, rsp_valid=0, busy=0, g_x*/g_y*=0, and g_random=seed[WIDTH-1:0].
  - Operations in flight are dropped; no rsp_valid is produced for them after reset is released.
- Issue enable: can_issue = (gap_cnt==0) and not rst.
- Arbitration (combinational from registered state):
  - If can_issue, grant the requester with req_valid set.
  - If both are valid, grant the requester selected by ptr.
  - req_ready = one-hot grant; at most one bit is set.
- Handshake and requester rules:
  - An issue occurs in a cycle with req_valid[i] & req_ready[i].
  - A requester holds valid and data stable until it is granted.
  - Dropping valid before grant is legal; the request is simply withdrawn.
- Gadget drive:
  - In an issue cycle, g_x0/g_x1/g_y0/g_y1 = the granted requester's shares.
  - Otherwise all four = 0 (precharge).
  - The requester data is never muxed onto the gadget unless granted.
- Randomness:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifted left, feedback into bit 0.
  - Advances every cycle out of reset.
  - g_random = lfsr[WIDTH-1:0] every cycle, so the mask consumed by the gadget's second stage (issue cycle + 1) is always a fresh value.
  - The LFSR never reaches 0.
- Per issue to requester i:
  - ptr <= ~i.
  - gap_cnt <= ISSUE_GAP.
  - issue_count++, wrapping 0xFFFF -> 0.
  - vld_s1 <= 1, tag_s1 <= i.
- Non-issue cycles:
  - gap_cnt decrements while nonzero.
  - vld_s1 <= 0.
- Pipeline tracking: vld_s2/tag_s2 <= vld_s1/tag_s1 every cycle.
- Response:
  - rsp_valid[i] = vld_s2 & (tag_s2==i).
  - rsp_z = {g_z1, g_z0} passed through.
  - Latency is exactly 2 cycles: issue in cycle t -> rsp_valid in cycle t+2.
  - Responses have no backpressure; the requester must accept the result in that cycle.
- Throughput and fairness:
  - With ISSUE_GAP=0, one issue per cycle and two operations in flight max.
  - With ISSUE_GAP=G, issues are G+1 cycles apart.
- busy = vld_s1 | vld_s2 | (gap_cnt!=0).

Test Plan:
- Reset, then single op on req0 with x0=3, x1=5, y0=A, y1=6, gadget instantiated -> req_ready[0]=1 in cycle t, rsp_valid=2'b01 at t+2, z0^z1 = 4'h4, busy low at t+3.
- Both requesters valid continuously, ISSUE_GAP=0 -> grants alternate 0,1,0,1; rsp_valid alternates 01,10 starting 2 cycles after the first grant; every result unmasks to x&y; issue_count=4 after 4 cycles.
- ISSUE_GAP=3, req1 held valid for 12 cycles -> grants at cycles 0, 4, 8 only; gap_cnt sequence 3,2,1,0; req_ready=0 in between; g_x*/g_y*=0 in non-issue cycles.
- LFSR check -> g_random follows the seed-derived sequence; no two consecutive cycles show identical 16-bit LFSR state; LFSR_SEED=0 behaves exactly as seed ACE1.
- Async rst asserted one cycle after an issue -> rsp_valid, req_ready and vld_s* drop immediately without a clock edge; no response appears after release; issue_count=0.
- issue_count preloaded to 0xFFFF via 65535 issues (or force) -> next issue wraps it to 0x0000.
